// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one I2C engine between NREQ sensor controllers.
// Round-robin grant held for exactly one engine transaction, with a
// transaction watchdog and a release phase that keeps bus_en low between grants.
module i2c_bus_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_en,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [32*NREQ-1:0]   req_wdata,
  input  logic [32*NREQ-1:0]   req_rdata,
  input  logic [5*NREQ-1:0]    req_nm,
  output logic [NREQ-1:0]      req_done,
  output logic [8*NREQ-1:0]    req_err_time,
  output logic [NREQ-1:0]      req_timeout,
  output logic [24*NREQ-1:0]   req_readdata,
  output logic [NREQ-1:0]      grant,
  output logic                 bus_en,
  output logic                 bus_wr,
  output logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic [4:0]           bus_nm,
  input  logic                 bus_done,
  input  logic [7:0]           bus_err_time,
  input  logic [23:0]          bus_readdata,
  output logic [7:0]           timeout_cnt
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           gidx_q, gidx_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic                 bus_en_q, bus_en_d;
  logic                 bus_wr_q, bus_wr_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;
  logic [31:0]          bus_rdata_q, bus_rdata_d;
  logic [4:0]           bus_nm_q, bus_nm_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic [NREQ-1:0]      tmo_q, tmo_d;
  logic [24*NREQ-1:0]   rdata_q, rdata_d;
  logic [7:0]           tcnt_q, tcnt_d;

  logic                 pick_found_s;
  logic [1:0]           pick_idx_s;
  logic [1:0]           sel_idx_s;
  logic                 sel_en_s;
  logic                 sel_wr_s;
  logic [31:0]          sel_wdata_s;
  logic [31:0]          sel_rdata_s;
  logic [4:0]           sel_nm_s;

  // Round-robin scan: first asserted request after the last served index.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_found_s && req_en[i] && (((int'(last_q) + k) % NREQ) == i)) begin
          pick_found_s = 1'b1;
          pick_idx_s   = 2'(i);
        end else begin
          pick_found_s = pick_found_s;
        end
      end
    end
  end

  // Command mux: the winning slice while idle, the held grant otherwise.
  always_comb begin
    sel_idx_s   = (state_q == ST_IDLE) ? pick_idx_s : gidx_q;
    sel_en_s    = 1'b0;
    sel_wr_s    = 1'b0;
    sel_wdata_s = 32'd0;
    sel_rdata_s = 32'd0;
    sel_nm_s    = 5'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx_s == 2'(i)) begin
        sel_en_s    = req_en[i];
        sel_wr_s    = req_wr[i];
        sel_wdata_s = req_wdata[32*i +: 32];
        sel_rdata_s = req_rdata[32*i +: 32];
        sel_nm_s    = req_nm[5*i +: 5];
      end else begin
        sel_en_s    = sel_en_s;
      end
    end
  end

  // Arbitration FSM: next state and all registered outputs.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    bus_en_d    = 1'b0;
    bus_wr_d    = bus_wr_q;
    bus_wdata_d = bus_wdata_q;
    bus_rdata_d = bus_rdata_q;
    bus_nm_d    = bus_nm_q;
    wd_d        = wd_q;
    done_d      = done_q;
    tmo_d       = tmo_q;
    rdata_d     = rdata_q;
    tcnt_d      = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          // Fields are loaded with the grant so they settle before en rises.
          gidx_d      = pick_idx_s;
          bus_wr_d    = sel_wr_s;
          bus_wdata_d = sel_wdata_s;
          bus_rdata_d = sel_rdata_s;
          bus_nm_d    = sel_nm_s;
          for (int i = 0; i < NREQ; i++) begin
            grant_d[i] = (pick_idx_s == 2'(i));
          end
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        bus_wr_d    = sel_wr_s;
        bus_wdata_d = sel_wdata_s;
        bus_rdata_d = sel_rdata_s;
        bus_nm_d    = sel_nm_s;
        wd_d        = '0;
        bus_en_d    = 1'b1;
        state_d     = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Track wr/rdata changes inside a combined write-then-read step.
        bus_wr_d    = sel_wr_s;
        bus_wdata_d = sel_wdata_s;
        bus_rdata_d = sel_rdata_s;
        bus_nm_d    = sel_nm_s;
        wd_d        = wd_q + WDW'(1);
        if (!sel_en_s) begin
          bus_en_d = 1'b0;
          state_d  = ST_RELEASE;
        end else if (bus_done) begin
          // Done outranks a watchdog expiry in the same cycle.
          bus_en_d = 1'b0;
          for (int i = 0; i < NREQ; i++) begin
            if (gidx_q == 2'(i)) begin
              done_d[i]            = 1'b1;
              rdata_d[24*i +: 24]  = bus_readdata;
            end else begin
              done_d[i]            = done_q[i];
            end
          end
          state_d = ST_RELEASE;
        end else if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
          bus_en_d = 1'b0;
          for (int i = 0; i < NREQ; i++) begin
            if (gidx_q == 2'(i)) begin
              tmo_d[i] = 1'b1;
            end else begin
              tmo_d[i] = tmo_q[i];
            end
          end
          if (tcnt_q != 8'hFF) begin
            tcnt_d = tcnt_q + 8'd1;
          end else begin
            tcnt_d = tcnt_q;
          end
          state_d = ST_RELEASE;
        end else begin
          bus_en_d = 1'b1;
          state_d  = ST_ACTIVE;
        end
      end
      ST_RELEASE: begin
        // Hold the grant until the requester drops en, then rotate.
        if (!sel_en_s) begin
          done_d  = done_q & ~grant_q;
          tmo_d   = tmo_q & ~grant_q;
          last_d  = gidx_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 2'(NREQ - 1);
      gidx_q      <= 2'd0;
      grant_q     <= '0;
      bus_en_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_wdata_q <= 32'd0;
      bus_rdata_q <= 32'd0;
      bus_nm_q    <= 5'd0;
      wd_q        <= '0;
      done_q      <= '0;
      tmo_q       <= '0;
      rdata_q     <= '0;
      tcnt_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      bus_en_q    <= bus_en_d;
      bus_wr_q    <= bus_wr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_rdata_q <= bus_rdata_d;
      bus_nm_q    <= bus_nm_d;
      wd_q        <= wd_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Error counter reaches only the requester currently holding the grant.
  always_comb begin
    req_err_time = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state_q != ST_IDLE) && (gidx_q == 2'(i))) begin
        req_err_time[8*i +: 8] = bus_err_time;
      end else begin
        req_err_time[8*i +: 8] = 8'd0;
      end
    end
  end

  assign req_done     = done_q;
  assign req_timeout  = tmo_q;
  assign req_readdata = rdata_q;
  assign grant        = grant_q;
  assign bus_en       = bus_en_q;
  assign bus_wr       = bus_wr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_rdata    = bus_rdata_q;
  assign bus_nm       = bus_nm_q;
  assign timeout_cnt  = tcnt_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Testbench for i2c_bus_arbiter: directed scenarios plus randomized
// transactions checked against a queue-level round-robin model.
module tb_i2c_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 100;

  logic            clk_in = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_en;
  logic [N-1:0]    req_wr;
  logic [32*N-1:0] req_wdata;
  logic [32*N-1:0] req_rdata;
  logic [5*N-1:0]  req_nm;
  logic [N-1:0]    req_done;
  logic [8*N-1:0]  req_err_time;
  logic [N-1:0]    req_timeout;
  logic [24*N-1:0] req_readdata;
  logic [N-1:0]    grant;
  logic            bus_en, bus_wr;
  logic [31:0]     bus_wdata, bus_rdata;
  logic [4:0]      bus_nm;
  logic            bus_done;
  logic [7:0]      bus_err_time;
  logic [23:0]     bus_readdata;
  logic [7:0]      timeout_cnt;

  i2c_bus_arbiter #(.NREQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .req_en(req_en), .req_wr(req_wr), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_nm(req_nm),
    .req_done(req_done), .req_err_time(req_err_time),
    .req_timeout(req_timeout), .req_readdata(req_readdata),
    .grant(grant), .bus_en(bus_en), .bus_wr(bus_wr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_nm(bus_nm),
    .bus_done(bus_done), .bus_err_time(bus_err_time),
    .bus_readdata(bus_readdata), .timeout_cnt(timeout_cnt)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Reference model: pending set, last served index, captured data, abort count.
  logic [N-1:0] m_pend;
  int           m_last;
  logic [23:0]  m_rd [N];
  int           m_tcnt;
  logic         f_wr    [N];
  logic [31:0]  f_wdata [N];
  logic [31:0]  f_rdata [N];
  logic [4:0]   f_nm    [N];

  task automatic chk_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i);
    req_wr[i]              = f_wr[i];
    req_wdata[32*i +: 32]  = f_wdata[i];
    req_rdata[32*i +: 32]  = f_rdata[i];
    req_nm[5*i +: 5]       = f_nm[i];
  endtask

  task automatic raise(input int i);
    f_wr[i]    = 1'($urandom);
    f_wdata[i] = $urandom;
    f_rdata[i] = $urandom;
    f_nm[i]    = 5'($urandom_range(1, 31));
    put(i);
    req_en[i] = 1'b1;
    m_pend[i] = 1'b1;
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      if (m_pend[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [24*N-1:0] rd_pack();
    logic [24*N-1:0] p;
    for (int i = 0; i < N; i++) p[24*i +: 24] = m_rd[i];
    return p;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    m_tcnt = 0;
    for (int i = 0; i < N; i++) m_rd[i] = 24'd0;
  endtask

  // One full grant: kind 0 = engine done, 1 = requester abort, 2 = watchdog.
  task automatic do_txn(input int kind, input int dly, input logic [23:0] rd, input logic [7:0] et);
    int w;
    int n;
    int cnt;
    int hold;
    logic [N-1:0]   oh;
    logic [8*N-1:0] e_et;
    w = rr_pick();
    if (w < 0) begin
      chk_eq("no_pending", 96'd0, 96'd1);
      return;
    end
    oh = '0;
    oh[w] = 1'b1;
    e_et = '0;
    e_et[8*w +: 8] = et;
    bus_err_time = et;
    n = 0;
    while (grant == '0 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    if (grant == '0) begin
      chk_eq("grant_wait", 96'd0, 96'd1);
      return;
    end
    chk_eq("grant", 96'(grant), 96'(oh));
    chk_eq("load_en", 96'(bus_en), 96'd0);
    chk_eq("load_wdata", 96'(bus_wdata), 96'(f_wdata[w]));
    chk_eq("load_nm", 96'(bus_nm), 96'(f_nm[w]));
    chk_eq("err_load", 96'(req_err_time), 96'(e_et));
    for (int i = 0; i < N; i++) begin
      if (i != w && !m_pend[i] && $urandom_range(0, 1) == 1) raise(i);
    end
    @(negedge clk_in);
    chk_eq("act_en", 96'(bus_en), 96'd1);
    chk_eq("act_wr", 96'(bus_wr), 96'(f_wr[w]));
    chk_eq("act_wdata", 96'(bus_wdata), 96'(f_wdata[w]));
    chk_eq("act_rdata", 96'(bus_rdata), 96'(f_rdata[w]));
    chk_eq("act_nm", 96'(bus_nm), 96'(f_nm[w]));
    if (kind == 1) begin
      repeat (dly) @(negedge clk_in);
      req_en[w] = 1'b0;
      m_pend[w] = 1'b0;
      @(negedge clk_in);
      chk_eq("abort_en", 96'(bus_en), 96'd0);
      chk_eq("abort_done", 96'(req_done), 96'd0);
      @(negedge clk_in);
      chk_eq("abort_grant", 96'(grant), 96'd0);
      m_last = w;
      return;
    end
    if (kind == 0) begin
      if (dly > 0) begin
        f_wdata[w] = $urandom;
        f_wr[w]    = ~f_wr[w];
        put(w);
        @(negedge clk_in);
        chk_eq("track_wdata", 96'(bus_wdata), 96'(f_wdata[w]));
        chk_eq("track_wr", 96'(bus_wr), 96'(f_wr[w]));
        repeat (dly - 1) @(negedge clk_in);
      end
      bus_done     = 1'b1;
      bus_readdata = rd;
      @(negedge clk_in);
      bus_done     = 1'b0;
      bus_readdata = 24'($urandom);
      m_rd[w] = rd;
      chk_eq("done_en", 96'(bus_en), 96'd0);
      chk_eq("done_lvl", 96'(req_done), 96'(oh));
      chk_eq("done_tmo", 96'(req_timeout), 96'd0);
      chk_eq("readdata", 96'(req_readdata), 96'(rd_pack()));
      chk_eq("err_rel", 96'(req_err_time), 96'(e_et));
    end else begin
      cnt = 1;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk_in);
        if (bus_en) cnt++;
        else break;
      end
      if (m_tcnt < 255) m_tcnt++;
      chk_eq("wd_len", 96'(cnt), 96'(TO));
      chk_eq("wd_flag", 96'(req_timeout), 96'(oh));
      chk_eq("wd_nodone", 96'(req_done), 96'd0);
      chk_eq("wd_cnt", 96'(timeout_cnt), 96'(m_tcnt));
    end
    hold = $urandom_range(0, 3);
    repeat (hold) @(negedge clk_in);
    chk_eq("hold_grant", 96'(grant), 96'(oh));
    chk_eq("hold_done", 96'(req_done), (kind == 0) ? 96'(oh) : 96'd0);
    req_en[w] = 1'b0;
    m_pend[w] = 1'b0;
    @(negedge clk_in);
    chk_eq("rel_grant", 96'(grant), 96'd0);
    chk_eq("rel_done", 96'(req_done), 96'd0);
    chk_eq("rel_tmo", 96'(req_timeout), 96'd0);
    chk_eq("rel_err", 96'(req_err_time), 96'd0);
    chk_eq("tcnt", 96'(timeout_cnt), 96'(m_tcnt));
    m_last = w;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] msk;
    int r;
    int kind;
    reset_n = 1'b0;
    req_en = '0; req_wr = '0; req_wdata = '0; req_rdata = '0; req_nm = '0;
    bus_done = 1'b0; bus_err_time = 8'd0; bus_readdata = 24'd0;
    m_pend = '0;
    model_reset();
    repeat (3) @(negedge clk_in);
    chk_eq("rst_grant", 96'(grant), 96'd0);
    chk_eq("rst_en", 96'(bus_en), 96'd0);
    chk_eq("rst_done", 96'(req_done), 96'd0);
    chk_eq("rst_rd", 96'(req_readdata), 96'd0);
    chk_eq("rst_tcnt", 96'(timeout_cnt), 96'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Single requester with fixed frame and grant latency.
    raise(0);
    f_wdata[0] = 32'h00D06B40;
    f_nm[0]    = 5'd3;
    put(0);
    @(negedge clk_in);
    chk_eq("lat_grant", 96'(grant), 96'b001);
    do_txn(0, 28, 24'hA5A5A5, 8'd0);

    // Contention, immediate re-assert of req 0, read capture and error isolation.
    raise(0);
    raise(1);
    do_txn(0, 3, 24'h000111, 8'd0);
    raise(0);
    do_txn(0, 2, 24'h12ABCD, 8'd5);
    do_txn(0, 1, 24'h0F0F0F, 8'd7);

    // Watchdog, abort, and done on the final watchdog cycle.
    raise(2);
    do_txn(2, 0, 24'd0, 8'd1);
    while (m_pend != '0) do_txn(0, 1, 24'($urandom), 8'd2);
    raise(1);
    do_txn(1, 4, 24'd0, 8'd3);
    while (m_pend != '0) do_txn(0, 1, 24'($urandom), 8'd2);
    raise(0);
    do_txn(0, TO - 1, 24'h5A5A5A, 8'd4);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      if (m_pend == '0) begin
        msk = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) if (msk[i]) raise(i);
      end
      r = $urandom_range(0, 19);
      kind = (r < 15) ? 0 : ((r < 18) ? 1 : 2);
      do_txn(kind, $urandom_range(0, 6), 24'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0 && !m_pend[m_last]) raise(m_last);
    end
    while (m_pend != '0) do_txn(0, 1, 24'($urandom), 8'd0);

    // Asynchronous reset in the middle of a transaction.
    raise(1);
    repeat (2) @(negedge clk_in);
    chk_eq("pre_rst_en", 96'(bus_en), 96'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_eq("arst_en", 96'(bus_en), 96'd0);
    chk_eq("arst_grant", 96'(grant), 96'd0);
    chk_eq("arst_rd", 96'(req_readdata), 96'd0);
    chk_eq("arst_tcnt", 96'(timeout_cnt), 96'd0);
    model_reset();
    raise(0);
    @(negedge clk_in);
    reset_n = 1'b1;
    do_txn(0, 2, 24'h00BEEF, 8'd9);
    while (m_pend != '0) do_txn(0, 1, 24'($urandom), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one I2C_Bus engine between up to four sensor controllers, e.g. the accelerometer sequencer and the pressure-sensor sequencer.
- Each controller keeps its native I2C_en/I2C_wr/I2C_wdata/I2C_rdata/I2C_NM command interface and receives done, error-count and ReadData back unchanged.
- Selects requesters round-robin and holds each grant for exactly one engine transaction.
- Provides a transaction watchdog and a release guard, so the engine always sees en low between transactions.

Parameters:
- NREQ, 2, number of requesters (legal range 2..4).
- TIMEOUT_CYC, 50000, maximum clk_in cycles in ACTIVE before the transaction is forcibly aborted.

Ports:
- clk_in  in  1  I2C state clock (same clock as the engine).
- reset_n  in  1  asynchronous, active-low reset.
- req_en  in  NREQ  per-requester I2C_en level.
- req_wr  in  NREQ  per-requester I2C_wr.
- req_wdata  in  32*NREQ  per-requester write frame; slice i is [32i+31:32i].
- req_rdata  in  32*NREQ  per-requester read frame.
- req_nm  in  5*NREQ  per-requester byte count.
- req_done  out  NREQ  per-requester done level.
- req_err_time  out  8*NREQ  per-requester error counter; the granted requester gets bus_err_time, all others get 0.
- req_timeout  out  NREQ  per-requester watchdog-abort flag.
- req_readdata  out  24*NREQ  per-requester captured ReadData.
- grant  out  NREQ  one-hot grant, 0 when no grant is held.
- bus_en, bus_wr  out  1  engine controls.
- bus_wdata, bus_rdata  out  32  engine frames.
- bus_nm  out  5  engine byte count.
- bus_done  in  1  engine done.
- bus_err_time  in  8  engine error counter.
- bus_readdata  in  24  engine ReadData.
- timeout_cnt  out  8  saturating count of watchdog aborts.

Behaviour:
- Reset (asynchronous) clears every output and register to 0. Round-robin pointer last = NREQ-1, so requester 0 wins first. State = IDLE. bus_en drops immediately, even mid-transaction.
- IDLE:
  - Scan req_en starting at last+1 and wrapping modulo NREQ.
  - First asserted index g: latch g, set grant[g]=1, go to LOAD.
  - No request: stay in IDLE.
- LOAD (1 cycle):
  - Register bus_wr, bus_wdata, bus_rdata, bus_nm from slice g. bus_en stays 0, so the fields are stable one cycle before en.
  - Clear the watchdog counter. Go to ACTIVE.
- ACTIVE:
  - bus_en=1 and the watchdog increments every cycle.
  - Command fields are re-registered from slice g every cycle, to track the requester's wr/rdata switch inside a combined read step.
  - Exits are checked in priority order:
    - (a) req_en[g]=0 (requester abort): bus_en<=0, go to RELEASE, no done.
    - (b) bus_done=1: bus_en<=0, req_readdata[g]<=bus_readdata, req_done[g]<=1, go to RELEASE.
    - (c) watchdog == TIMEOUT_CYC-1: bus_en<=0, req_timeout[g]<=1, timeout_cnt increments (saturating at 255), go to RELEASE.
  - If (b) and (c) occur in the same cycle, done wins and no timeout is recorded.
- RELEASE:
  - bus_en=0. Hold until req_en[g]=0.
  - Then clear req_done[g] and req_timeout[g], set last<=g, clear grant, and go to IDLE.
  - This guarantees bus_en is low for at least 2 cycles between grants.
  - A requester that re-asserts immediately is served only after the other pending requesters.
- Latency: req_en rising in IDLE at cycle N gives grant at N+1 (LOAD) and bus_en at N+2. bus_done at cycle M gives req_done[g] and bus_en=0 at M+1.
- Level semantics:
  - req_done[g] is a level from M+1 until req_en[g] falls; requesters sample it as the engine's done.
  - Non-granted req_done and req_timeout are 0.
  - req_readdata slices hold their last captured value.
- req_err_time: the granted requester's slice mirrors bus_err_time combinationally in LOAD, ACTIVE and RELEASE; all other slices and states output 0. This lets each requester's error_time > limit check see only its own transactions.
- Simultaneous requests: exactly one grant, following round-robin order; losers keep req_en high and wait with no output activity.
- Grant changes only in IDLE. A requester's request is never dropped while it is asserted, and is served within NREQ-1 other transactions.

Test Plan:
- Single requester (NREQ=2): req_en[0] rises at cycle 10 with wdata 0xD06B40, nm 3. Expect bus_en=1 at cycle 12 and bus_wdata=0xD06B40. Engine done at cycle 40 → req_done[0]=1 at 41. req_en[0] drops at 42 → grant=0 at 43.
- Contention: req_en=2'b11 asserted together after reset. Expect req 0 served first, then req 1. Repeat with req 0 re-asserting immediately → order is 0,1,0,1, never 0,0.
- Read capture: engine returns ReadData 0x12ABCD on req 1's transaction → req_readdata[1]=0x12ABCD; req_readdata[0] unchanged.
- Watchdog: TIMEOUT_CYC=100, engine never asserts done → bus_en drops at ACTIVE cycle 100, req_timeout[g]=1, timeout_cnt=1, no req_done.
- Abort and reset: req_en[0] dropped in mid-ACTIVE → bus_en=0 next cycle, no done, FSM returns to IDLE. Separately, reset_n pulsed low mid-ACTIVE → bus_en=0 and grant=0 immediately; requester 0 wins first after reset.
- Error isolation: bus_err_time=5 during req 1's grant → req_err_time[1]=5 and req_err_time[0]=0.
